bram18_port_arbiter: RTL and testbench
======================================

Name: bram18_port_arbiter

Overview:
Shares one 18K half-port of the split TDP36K block RAM (ADDR/WDATA/RDATA/REN/WEN/BE) among NREQ requesters.
- Arbitration is round-robin with a valid/ready handshake; at most one access per cycle.
- Read data is returned with a per-requester response strobe.
- After reset, an optional clear sequencer writes zero to the RAM before any requester is served.
- Sits between user logic and one port group (A1/B1/A2/B2) of the BRAM2x18 wrappers.

Parameters:
- DBITS, 18, data width (1, 2, 4, 8, 9, 16 or 18).
- ABITS, 14, port address width.
- BEBITS, 2, byte-enable width.
- NREQ, 2, number of requesters (2..4).
- CLEAR_ON_RESET, 1, when 1, the RAM is zero-filled after reset.
- CLEAR_WORDS, 1024, number of addresses cleared (0..CLEAR_WORDS-1); must be at least 1 and at most 2^ABITS.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  NREQ  request valid, one bit per requester.
- REQ_READY  out  NREQ  grant/accept, one-hot or zero.
- REQ_WE  in  NREQ  1 = write, 0 = read.
- REQ_ADDR  in  NREQ*ABITS  packed addresses; requester i uses slice [i*ABITS +: ABITS].
- REQ_WDATA  in  NREQ*DBITS  packed write data.
- REQ_BE  in  NREQ*BEBITS  packed byte enables.
- RSP_VALID  out  NREQ  read-data strobe to the owning requester.
- RSP_RDATA  out  DBITS  read data, shared by all requesters.
- BUSY  out  1  high while clearing.
- BRAM_ADDR  out  ABITS  to the RAM port.
- BRAM_WDATA  out  DBITS  to the RAM port.
- BRAM_BE  out  BEBITS  to the RAM port.
- BRAM_REN  out  1  to the RAM port.
- BRAM_WEN  out  1  to the RAM port.
- BRAM_RDATA  in  DBITS  from the RAM port; valid 1 cycle after REN is sampled.

Behaviour:
- FSM states are CLEAR and RUN.
- Reset values:
  - State = CLEAR if CLEAR_ON_RESET, else RUN.
  - Clear counter = 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - All BRAM_* outputs = 0; RSP_VALID = 0; read pipeline flags cleared.
  - BUSY = 1 if CLEAR_ON_RESET, else 0.
- CLEAR state:
  - REQ_READY = 0.
  - Registered outputs each cycle: BRAM_WEN = 1, BRAM_BE = all ones, BRAM_WDATA = 0, BRAM_ADDR = counter.
  - Counter increments every cycle.
  - On the cycle the counter = CLEAR_WORDS-1 is issued, move to RUN; BUSY falls on the following cycle.
- RUN state:
  - Grant goes to the first requester with REQ_VALID=1, searching from (ptr+1) mod NREQ upward with wrap.
  - REQ_READY[g] = 1 combinationally for that requester only, so READY depends on VALID.
  - Accept = VALID & READY. On accept at cycle N, the pointer becomes g.
  - Register at cycle N+1: BRAM_ADDR/WDATA/BE from requester g, BRAM_WEN = REQ_WE, BRAM_REN = !REQ_WE.
  - With no accept, the next cycle has REN = WEN = 0; ADDR/WDATA/BE hold their previous values.
- Read return:
  - Requester id is pipelined two stages.
  - RSP_VALID[g] = 1 for exactly one cycle at N+2.
  - RSP_RDATA = BRAM_RDATA, combinational pass-through, valid when any RSP_VALID bit is set.
  - Writes produce no response.
- Throughput: one accept per cycle, back-to-back, with no bubble between requesters or between read and write.
- Hazards:
  - A read accepted the cycle after a write to the same address returns the RAM's write-mode behaviour; the arbiter does not forward.
- Reset mid-operation:
  - In-flight reads are dropped, with no RSP_VALID after RST.
  - CLEAR restarts at address 0.
- A request held (VALID high, not granted) must keep ADDR/WDATA/BE/WE stable; the arbiter never grants a requester whose VALID = 0.

Decomposition:
- Package bram18_arb_pkg:
  - FSM state enum {CLEAR, RUN}.
  - Mode-width constants (1/2/4/9/18).
  - Function rr_next(valid, ptr) returning the grant index.
- Sub-module rr_arbiter (NREQ): combinational grant plus registered pointer with an advance input; reusable by the other wrapper controllers.

Test Plan:
1. Clear: CLEAR_ON_RESET=1, CLEAR_WORDS=16; release RST at cycle 0.
   -> BRAM_WEN=1 with ADDR 0..15 on cycles 1..16, WDATA=0, BE=2'b11.
   -> BUSY deasserts at cycle 17; REQ_READY=0 throughout.
2. Round-robin: both VALID held high, reads to 0x10 (req0) and 0x20 (req1).
   -> Grants alternate 0,1,0,1; BRAM_ADDR alternates 0x10/0x20 each cycle.
   -> RSP_VALID alternates 01/10, starting 2 cycles after the first grant.
3. Write then read: req1 writes 18'h2ABCD, BE=11, at 0x05; req1 then reads 0x05.
   -> RSP_VALID[1]=1 with RSP_RDATA=18'h2ABCD.
4. Byte enable: write 18'h3FFFF to 0x07, then write 18'h00000 with BE=2'b01, then read.
   -> Read returns 18'h3FE00.
5. Reset mid-read: RST asserted one cycle after a read accept.
   -> No RSP_VALID afterwards; CLEAR restarts at ADDR 0.
6. Single requester: req0 streams 8 reads with req1 idle.
   -> 8 consecutive grants to req0 with no bubbles; 8 RSP_VALID[0] pulses in cycles N+2..N+9.

Source files
------------

// File: rtl/bram18_port_arbiter_pkg.sv
// Shared types and helpers for the BRAM18 half-port arbiter and its sibling
// wrapper controllers.
package bram18_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  // Legal data widths of one 18K half-port.
  localparam int MODE_W1  = 1;
  localparam int MODE_W2  = 2;
  localparam int MODE_W4  = 4;
  localparam int MODE_W9  = 9;
  localparam int MODE_W18 = 18;

  localparam int MAX_NREQ = 4;
  localparam int IDX_W    = 2;

  // First valid requester after ptr, searching upward with wrap over nreq slots.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_NREQ-1:0] valid,
                                               input logic [IDX_W-1:0]    ptr,
                                               input int                  nreq);
    logic [IDX_W-1:0] g;
    logic             hit;
    int               j;
    g   = ptr;
    hit = 1'b0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= nreq) j = j - nreq;
      if (k <= nreq && !hit && valid[j[IDX_W-1:0]]) begin
        hit = 1'b1;
        g   = j[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bram18_port_arbiter_if.sv
// Requester-side bus of the BRAM18 half-port arbiter: packed per-requester
// request fields plus the shared read-return path.
interface bram18_port_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ABITS  = 14,
  parameter int DBITS  = 18,
  parameter int BEBITS = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ABITS-1:0]  req_addr;
  logic [NREQ*DBITS-1:0]  req_wdata;
  logic [NREQ*BEBITS-1:0] req_be;
  logic [NREQ-1:0]        rsp_valid;
  logic [DBITS-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram18_port_arbiter_rr_arbiter.sv
// Round-robin grant with a registered last-winner pointer; the pointer moves
// to the granted index only when the caller signals advance.
module rr_arbiter
  import bram18_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    idx;
  logic [MAX_NREQ-1:0] valid_ext;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    idx                   = rr_next(valid_ext, ptr, NREQ);
    any                   = |valid;
    grant                 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (any && idx == IDX_W'(i)) grant[i] = 1'b1;
    end
  end

  // Reset to the last slot so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) ptr <= IDX_W'(NREQ - 1);
    else if (advance) ptr <= idx;
  end

endmodule

// File: rtl/bram18_port_arbiter.sv
// Shares one BRAM18 half-port among NREQ requesters, zero-filling the RAM after reset.
//   state | meaning
//   CLEAR | writing zero to addresses 0..CLEAR_WORDS-1, requesters held off
//   RUN   | round-robin service, one access per cycle
module bram18_port_arbiter
  import bram18_arb_pkg::*;
#(
  parameter int DBITS          = MODE_W18,
  parameter int ABITS          = 14,
  parameter int BEBITS         = 2,
  parameter int NREQ           = 2,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CLEAR_WORDS    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  bram18_port_arbiter_if.slave bus,
  output logic                 busy,
  output logic [ABITS-1:0]     bram_addr,
  output logic [DBITS-1:0]     bram_wdata,
  output logic [BEBITS-1:0]    bram_be,
  output logic                 bram_ren,
  output logic                 bram_wen,
  input  logic [DBITS-1:0]     bram_rdata
);

  localparam arb_state_t       INIT_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [ABITS-1:0] CLR_LAST   = ABITS'(CLEAR_WORDS - 1);

  arb_state_t        state;
  logic [ABITS-1:0]  clr_cnt;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rd_pipe;
  logic              any;
  logic              accept;
  logic              sel_we;
  logic [ABITS-1:0]  sel_addr;
  logic [DBITS-1:0]  sel_wdata;
  logic [BEBITS-1:0] sel_be;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .any     (any)
  );

  // Grant is only ever given to a valid requester, so READY alone implies accept.
  assign accept        = (state == RUN) && any;
  assign bus.req_ready = (state == RUN) ? grant : '0;
  assign bus.rsp_rdata = bram_rdata;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ABITS +: ABITS];
        sel_wdata = bus.req_wdata[i*DBITS +: DBITS];
        sel_be    = bus.req_be[i*BEBITS +: BEBITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT_STATE;
      clr_cnt       <= '0;
      busy          <= (CLEAR_ON_RESET != 0);
      bram_addr     <= '0;
      bram_wdata    <= '0;
      bram_be       <= '0;
      bram_ren      <= 1'b0;
      bram_wen      <= 1'b0;
      rd_pipe       <= '0;
      bus.rsp_valid <= '0;
    end else begin
      busy          <= (state == CLEAR);
      rd_pipe       <= (accept && !sel_we) ? grant : '0;
      bus.rsp_valid <= rd_pipe;
      case (state)
        CLEAR: begin
          bram_wen   <= 1'b1;
          bram_ren   <= 1'b0;
          bram_be    <= '1;
          bram_wdata <= '0;
          bram_addr  <= clr_cnt;
          clr_cnt    <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) state <= RUN;
        end
        default: begin
          bram_wen <= accept && sel_we;
          bram_ren <= accept && !sel_we;
          if (accept) begin
            bram_addr  <= sel_addr;
            bram_wdata <= sel_wdata;
            bram_be    <= sel_be;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram18_port_arbiter.sv
// Self-checking bench for bram18_port_arbiter: RAM behavioural model on the
// port side, round-robin/shadow-memory reference model on the requester side.
module tb_bram18_port_arbiter;
  localparam int DBITS       = 18;
  localparam int ABITS       = 14;
  localparam int BEBITS      = 2;
  localparam int NREQ        = 2;
  localparam int CLEAR_WORDS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic [ABITS-1:0]  bram_addr;
  logic [DBITS-1:0]  bram_wdata;
  logic [BEBITS-1:0] bram_be;
  logic              bram_ren;
  logic              bram_wen;
  logic [DBITS-1:0]  bram_rdata;

  always #5 clk = ~clk;

  bram18_port_arbiter_if #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .BEBITS(BEBITS)) bus ();

  bram18_port_arbiter #(
    .DBITS(DBITS), .ABITS(ABITS), .BEBITS(BEBITS), .NREQ(NREQ),
    .CLEAR_ON_RESET(1), .CLEAR_WORDS(CLEAR_WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_be    (bram_be),
    .bram_ren   (bram_ren),
    .bram_wen   (bram_wen),
    .bram_rdata (bram_rdata)
  );

  // RAM port model: 9-bit byte lanes, read data one cycle after REN, read-first.
  logic [DBITS-1:0] ram [0:(1<<ABITS)-1];
  logic [DBITS-1:0] ram_q;
  assign bram_rdata = ram_q;
  always @(posedge clk) begin
    if (bram_wen) begin
      if (bram_be[0]) ram[bram_addr][8:0]  <= bram_wdata[8:0];
      if (bram_be[1]) ram[bram_addr][17:9] <= bram_wdata[17:9];
    end
    if (bram_ren) ram_q <= ram[bram_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0]   v_d, we_d;
  logic [ABITS-1:0]  a_d [NREQ];
  logic [DBITS-1:0]  d_d [NREQ];
  logic [BEBITS-1:0] b_d [NREQ];

  logic [DBITS-1:0]  shadow [0:63];
  int                ptr_m, g_m;
  logic [NREQ-1:0]   exp_ready, exp_rsp, p1_vec;
  logic [DBITS-1:0]  exp_rdata, p1_data, exp_wdata;
  logic              exp_wen, exp_ren;
  logic [ABITS-1:0]  exp_addr;
  logic [BEBITS-1:0] exp_be;

  task automatic drive();
    bus.req_valid = v_d;
    bus.req_we    = we_d;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*ABITS +: ABITS]    = a_d[i];
      bus.req_wdata[i*DBITS +: DBITS]   = d_d[i];
      bus.req_be[i*BEBITS +: BEBITS]    = b_d[i];
    end
  endtask

  task automatic idle_inputs();
    v_d = '0; we_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_d[i] = '0; d_d[i] = '0; b_d[i] = '0;
    end
  endtask

  task automatic model_reset();
    ptr_m = NREQ - 1;
    p1_vec = '0; p1_data = '0; exp_rsp = '0; exp_rdata = '0;
    exp_wen = 1'b0; exp_ren = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
  endtask

  // Winner = first valid requester after the previous winner, with wrap.
  task automatic model_predict();
    exp_ready = '0;
    g_m = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (ptr_m + k) % NREQ;
      if (g_m < 0 && v_d[j]) g_m = j;
    end
    if (g_m >= 0) exp_ready[g_m] = 1'b1;
  endtask

  task automatic model_commit();
    int a;
    exp_rsp   = p1_vec;
    exp_rdata = p1_data;
    p1_vec    = '0;
    exp_wen   = 1'b0;
    exp_ren   = 1'b0;
    if (g_m >= 0) begin
      a         = int'(a_d[g_m][5:0]);
      ptr_m     = g_m;
      exp_addr  = a_d[g_m];
      exp_wdata = d_d[g_m];
      exp_be    = b_d[g_m];
      if (we_d[g_m]) begin
        exp_wen = 1'b1;
        if (b_d[g_m][0]) shadow[a][8:0]  = d_d[g_m][8:0];
        if (b_d[g_m][1]) shadow[a][17:9] = d_d[g_m][17:9];
      end else begin
        exp_ren       = 1'b1;
        p1_vec[g_m]   = 1'b1;
        p1_data       = shadow[a];
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs(); drive();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bram_wen, bram_ren, bram_addr, bram_wdata, bram_be} !== '0) begin
      errors++; $display("FAIL reset_bram: got wen=%b ren=%b addr=%h wdata=%h be=%b want all zero",
                         bram_wen, bram_ren, bram_addr, bram_wdata, bram_be);
    end
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
      errors++; $display("FAIL reset_flags: got busy=%b rsp=%b ready=%b want 1/00/00",
                         busy, bus.rsp_valid, bus.req_ready);
    end
    rst = 1'b0;
    for (int k = 1; k <= CLEAR_WORDS; k++) begin
      @(negedge clk);
      v_d = 2'b11; drive(); #1;
      checks++;
      if (bram_wen !== 1'b1 || bram_ren !== 1'b0 || bram_addr !== ABITS'(k - 1) ||
          bram_wdata !== '0 || bram_be !== 2'b11) begin
        errors++; $display("FAIL clear_write cycle %0d: got wen=%b ren=%b addr=%0d wdata=%h be=%b want 1/0/%0d/0/11",
                           k, bram_wen, bram_ren, bram_addr, bram_wdata, bram_be, k - 1);
      end
      if (k < CLEAR_WORDS) begin
        checks++;
        if (busy !== 1'b1 || bus.req_ready !== '0) begin
          errors++; $display("FAIL clear_busy cycle %0d: got busy=%b ready=%b want 1/00", k, busy, bus.req_ready);
        end
      end
      v_d = '0; drive();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bram_wen !== 1'b0 || bram_ren !== 1'b0) begin
      errors++; $display("FAIL clear_done: got busy=%b wen=%b ren=%b want 0/0/0", busy, bram_wen, bram_ren);
    end
    model_reset();
  endtask

  task automatic test_round_robin();
    idle_inputs();
    a_d[0] = ABITS'(16'h0010); a_d[1] = ABITS'(16'h0020); b_d[0] = 2'b11; b_d[1] = 2'b11;
    for (int c = 0; c < 11; c++) begin
      v_d = (c < 8) ? 2'b11 : 2'b00;
      drive(); #1; model_predict();
      if (c < 8) begin
        checks++;
        if (bus.req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_alternate cycle %0d: got %b want %b", c, bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      checks++;
      if ({bram_wen, bram_ren} !== {exp_wen, exp_ren}) begin
        errors++; $display("FAIL rr_strobes cycle %0d: got %b%b want %b%b", c, bram_wen, bram_ren, exp_wen, exp_ren);
      end
      if (exp_ren) begin
        checks++;
        if (bram_addr !== exp_addr) begin
          errors++; $display("FAIL rr_addr cycle %0d: got %h want %h", c, bram_addr, exp_addr);
        end
      end
      checks++;
      if (bus.rsp_valid !== exp_rsp) begin
        errors++; $display("FAIL rr_rsp cycle %0d: got %b want %b", c, bus.rsp_valid, exp_rsp);
      end
      model_commit();
      @(negedge clk);
    end
  endtask

  task automatic test_write_read();
    int seen;
    seen = 0;
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      v_d = (c < 2) ? 2'b10 : 2'b00;
      we_d[1] = (c == 0);
      a_d[1] = ABITS'(5); d_d[1] = 18'h2ABCD; b_d[1] = 2'b11;
      drive(); #1; model_predict();
      checks++;
      if (bus.req_ready !== exp_ready || {bram_wen, bram_ren} !== {exp_wen, exp_ren}) begin
        errors++; $display("FAIL wr_rd_port cycle %0d: got ready=%b wen/ren=%b%b want %b %b%b",
                           c, bus.req_ready, bram_wen, bram_ren, exp_ready, exp_wen, exp_ren);
      end
      checks++;
      if (bus.rsp_valid !== exp_rsp) begin
        errors++; $display("FAIL wr_rd_rsp cycle %0d: got %b want %b", c, bus.rsp_valid, exp_rsp);
      end
      if (bus.rsp_valid == 2'b10 && bus.rsp_rdata === 18'h2ABCD) seen++;
      model_commit();
      @(negedge clk);
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL wr_rd_data: got %0d responses of 2abcd on req1 want 1", seen);
    end
  endtask

  task automatic test_byte_enable();
    int seen;
    seen = 0;
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      v_d = (c < 3) ? 2'b01 : 2'b00;
      we_d[0] = (c < 2);
      a_d[0] = ABITS'(7);
      d_d[0] = (c == 0) ? 18'h3FFFF : 18'h00000;
      b_d[0] = (c == 0) ? 2'b11 : 2'b01;
      drive(); #1; model_predict();
      checks++;
      if ({bram_wen, bram_ren} !== {exp_wen, exp_ren} ||
          ((exp_wen || exp_ren) && (bram_addr !== exp_addr || bram_be !== exp_be))) begin
        errors++; $display("FAIL be_port cycle %0d: got wen/ren=%b%b addr=%h be=%b want %b%b %h %b",
                           c, bram_wen, bram_ren, bram_addr, bram_be, exp_wen, exp_ren, exp_addr, exp_be);
      end
      if (bus.rsp_valid == 2'b01) begin
        seen++;
        checks++;
        if (bus.rsp_rdata !== 18'h3FE00) begin
          errors++; $display("FAIL be_data: got %h want 3fe00", bus.rsp_rdata);
        end
      end
      model_commit();
      @(negedge clk);
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL be_rsp_count: got %0d want 1", seen);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    exp_ready = '0;
    for (int c = 0; c < 303; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(v_d[i] && !exp_ready[i])) begin
          v_d[i]  = (c < 300) && ($urandom_range(0, 3) != 0);
          we_d[i] = $urandom_range(0, 1) != 0;
          a_d[i]  = ABITS'($urandom_range(0, 63));
          d_d[i]  = DBITS'($urandom);
          b_d[i]  = BEBITS'($urandom_range(0, 3));
        end
      end
      drive(); #1; model_predict();
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, bus.req_ready, exp_ready);
      end
      checks++;
      if ({bram_wen, bram_ren} !== {exp_wen, exp_ren}) begin
        errors++; $display("FAIL rand_strobes cycle %0d: got %b%b want %b%b", c, bram_wen, bram_ren, exp_wen, exp_ren);
      end
      if (exp_wen || exp_ren) begin
        checks++;
        if (bram_addr !== exp_addr || bram_be !== exp_be || (exp_wen && bram_wdata !== exp_wdata)) begin
          errors++; $display("FAIL rand_fields cycle %0d: got addr=%h be=%b wdata=%h want %h %b %h",
                             c, bram_addr, bram_be, bram_wdata, exp_addr, exp_be, exp_wdata);
        end
      end
      checks++;
      if (bus.rsp_valid !== exp_rsp) begin
        errors++; $display("FAIL rand_rsp cycle %0d: got %b want %b", c, bus.rsp_valid, exp_rsp);
      end
      if (exp_rsp != '0) begin
        checks++;
        if (bus.rsp_rdata !== exp_rdata) begin
          errors++; $display("FAIL rand_rdata cycle %0d: got %h want %h", c, bus.rsp_rdata, exp_rdata);
        end
      end
      model_commit();
      @(negedge clk);
    end
  endtask

  task automatic test_single_requester();
    int pulses, first, last;
    pulses = 0; first = -1; last = -1;
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      v_d = (c < 8) ? 2'b01 : 2'b00;
      a_d[0] = ABITS'($urandom_range(0, 63));
      b_d[0] = 2'b11;
      drive(); #1; model_predict();
      if (c < 8) begin
        checks++;
        if (bus.req_ready !== 2'b01) begin
          errors++; $display("FAIL single_grant cycle %0d: got %b want 01", c, bus.req_ready);
        end
      end
      checks++;
      if (bus.rsp_valid !== exp_rsp || (exp_rsp != '0 && bus.rsp_rdata !== exp_rdata)) begin
        errors++; $display("FAIL single_rsp cycle %0d: got %b/%h want %b/%h", c, bus.rsp_valid, bus.rsp_rdata, exp_rsp, exp_rdata);
      end
      if (bus.rsp_valid == 2'b01) begin
        pulses++;
        if (first < 0) first = c;
        last = c;
      end
      model_commit();
      @(negedge clk);
    end
    checks++;
    if (pulses != 8 || first != 2 || last != 9) begin
      errors++; $display("FAIL single_stream: got pulses=%0d first=%0d last=%0d want 8/2/9", pulses, first, last);
    end
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    v_d = 2'b01; a_d[0] = ABITS'(3); b_d[0] = 2'b11;
    drive();
    @(negedge clk);
    checks++;
    if (bram_ren !== 1'b1) begin
      errors++; $display("FAIL midrst_read_issued: got ren=%b want 1", bram_ren);
    end
    idle_inputs(); drive();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_drop: got rsp=%b busy=%b want 00/1", bus.rsp_valid, busy);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bram_wen !== 1'b1 || bram_addr !== ABITS'(k) || bus.rsp_valid !== '0) begin
        errors++; $display("FAIL midrst_clear k=%0d: got wen=%b addr=%0d rsp=%b want 1/%0d/00",
                           k, bram_wen, bram_addr, bus.rsp_valid, k);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ABITS); i++) ram[i] = '0;
    ram_q = '0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_byte_enable();
    test_random();
    test_single_requester();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
